// File: rtl/button_conditioner.sv
// Debounces three raw pushbuttons and turns each accepted press into a single
// registered one-clock pulse, with clear > stop > go priority between pulses.

module button_channel #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic rise,
    output logic level
);
    typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1, s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (clr) begin
            s1    <= 1'b0;
            s     <= 1'b0;
            state <= LOW;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s     <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter stops advancing at LAST because the state always leaves
    // the check state there, so it can never wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise      = 1'b0;
        case (state)
            LOW: begin
                if (s) begin
                    state_nxt = CHK_HI;
                    cnt_nxt   = '0;
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_nxt = LOW;
                end else if (cnt == LAST) begin
                    state_nxt = HIGH;
                    rise      = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    state_nxt = CHK_LO;
                    cnt_nxt   = '0;
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_nxt = HIGH;
                end else if (cnt == LAST) begin
                    state_nxt = LOW;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = LOW;
        endcase
    end

    assign level = (state == HIGH) || (state == CHK_LO);
endmodule

module button_conditioner #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_go,
    input  logic       btn_stop,
    input  logic       btn_clr,
    output logic       go,
    output logic       stop,
    output logic       clr_out,
    output logic [2:0] db_level
);
    localparam int NUM_BTN = 3;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] rise;

    assign raw = {btn_clr, btn_stop, btn_go};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk  (clk),
            .clr  (clr),
            .raw  (raw[i]),
            .rise (rise[i]),
            .level(db_level[i])
        );
    end

    // Losing pulses are dropped on the spot, never held for a later cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            go      <= 1'b0;
            stop    <= 1'b0;
            clr_out <= 1'b0;
        end else begin
            clr_out <= rise[2];
            stop    <= rise[1] & ~rise[2];
            go      <= rise[0] & ~rise[1] & ~rise[2];
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed scenarios plus random bouncy stimulus against a run-length
// debounce model: a level flips after DB+1 consecutive disagreeing samples.

module tb_button_conditioner;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       btn_go = 1'b0, btn_stop = 1'b0, btn_clr = 1'b0;
    logic       go, stop, clr_out;
    logic [2:0] db_level;

    button_conditioner #(.DB_CYCLES(DB), .CNT_W(4)) dut (
        .clk(clk), .clr(clr), .btn_go(btn_go), .btn_stop(btn_stop),
        .btn_clr(btn_clr), .go(go), .stop(stop), .clr_out(clr_out),
        .db_level(db_level)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc;
    int go_at, stop_at, clr_at, go_n, stop_n, clr_n;

    // reference model state
    logic [2:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pulse = '0;
    int         m_run [3] = '{0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic model_edge(input logic [2:0] b, input logic c);
        logic [2:0] acc, s;
        acc = '0;
        if (c) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
        end else begin
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = b;
            for (int i = 0; i < 3; i++) begin
                if (s[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB + 1) begin
                        m_lvl[i] = s[i];
                        m_run[i] = 0;
                        acc[i]   = s[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        m_pulse = {acc[2], acc[1] & ~acc[2], acc[0] & ~acc[1] & ~acc[2]};
    endtask

    task automatic clear_marks();
        cyc = 0;
        go_at = -1; stop_at = -1; clr_at = -1;
        go_n = 0; stop_n = 0; clr_n = 0;
    endtask

    // b = {clr, stop, go}
    task automatic step(input logic [2:0] b, input logic c);
        {btn_clr, btn_stop, btn_go} = b;
        clr = c;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(b, c);
        chk("out", {26'd0, clr_out, stop, go, db_level}, {26'd0, m_pulse, m_lvl});
        if (go)      begin go_n++;   if (go_at < 0)   go_at = cyc;   end
        if (stop)    begin stop_n++; if (stop_at < 0) stop_at = cyc; end
        if (clr_out) begin clr_n++;  if (clr_at < 0)  clr_at = cyc;  end
    endtask

    task automatic do_reset();
        step(3'b000, 1'b1);
        clear_marks();
    endtask

    initial begin
        logic [2:0] b;
        logic       c;
        clear_marks();
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        chk("rst_state", {28'd0, go, stop, clr_out, |db_level}, 32'd0);

        // clean press, held long
        clear_marks();
        for (int i = 0; i < 12; i++) step(3'b001, 1'b0);
        chk("go_lat", go_at, 7);
        chk("go_once", go_n, 1);
        chk("go_lvl", {31'd0, db_level[0]}, 32'd1);

        // release with a 2-clock glitch high
        step(3'b000, 1'b0);
        step(3'b001, 1'b0);
        step(3'b001, 1'b0);
        for (int i = 0; i < 6; i++) step(3'b000, 1'b0);
        chk("rel_held", {31'd0, db_level[0]}, 32'd1);
        for (int i = 0; i < 6; i++) step(3'b000, 1'b0);
        chk("rel_low", {31'd0, db_level[0]}, 32'd0);
        chk("rel_nogo", go_n, 1);

        // stop bounce then held
        do_reset();
        step(3'b010, 1'b0);
        step(3'b010, 1'b0);
        step(3'b000, 1'b0);
        for (int i = 0; i < 12; i++) step(3'b010, 1'b0);
        chk("bnc_lat", stop_at, 10);
        chk("bnc_once", stop_n, 1);

        // go + stop together
        do_reset();
        for (int i = 0; i < 9; i++) step(3'b011, 1'b0);
        chk("gs_stop", stop_at, 7);
        chk("gs_nogo", go_n, 0);

        // all three together
        do_reset();
        for (int i = 0; i < 9; i++) step(3'b111, 1'b0);
        chk("all_clr", clr_at, 7);
        chk("all_none", go_n + stop_n, 0);

        // reset mid-count with go held
        do_reset();
        for (int i = 0; i < 4; i++) step(3'b001, 1'b0);
        chk("mid_early", go_n, 0);
        step(3'b001, 1'b1);
        clear_marks();
        for (int i = 0; i < 10; i++) step(3'b001, 1'b0);
        chk("mid_lat", go_at, 7);
        chk("mid_once", go_n, 1);

        // short clr-button glitch
        do_reset();
        for (int i = 0; i < 3; i++) step(3'b100, 1'b0);
        for (int i = 0; i < 8; i++) step(3'b000, 1'b0);
        chk("glitch", clr_n, 0);
        chk("glitch_lvl", {31'd0, db_level[2]}, 32'd0);

        // random bouncy traffic with occasional resets
        do_reset();
        b = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 5) == 0) b[k] = ~b[k];
            c = ($urandom_range(0, 199) == 0);
            step(b, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
